// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem requests
// over req/ack and presents each fetched word to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] req_addr_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic [31:0] target_s;

  assign target_s = {redirect_pc[31:2], 2'b00};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= START;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      START: next_state_s = FETCH;
      FETCH: begin
        if (imem_ack && !redirect) begin
          next_state_s = HOLD;
        end else if (!imem_ack && redirect) begin
          next_state_s = DROP;
        end else begin
          next_state_s = FETCH;
        end
      end
      DROP: begin
        if (imem_ack) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = DROP;
        end
      end
      HOLD: begin
        if (redirect || inst_ready) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = START;
    endcase
  end

  // Output decode: outputs depend on state only, never on inputs
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state_r)
      START: begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
      end
      FETCH, DROP: begin
        imem_req   = 1'b1;
        inst_valid = 1'b0;
      end
      HOLD: begin
        imem_req   = 1'b0;
        inst_valid = 1'b1;
      end
      default: begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
      end
    endcase
  end

  // Datapath registers: PC, outstanding request address and the held instruction.
  // In DROP only pc moves on redirect, so the last redirect wins once the ack lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      inst_r     <= 32'h0000_0000;
      inst_pc_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        START: begin
          if (redirect) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
          end else begin
            req_addr_r <= pc_r;
          end
        end
        FETCH: begin
          if (imem_ack && !redirect) begin
            inst_r    <= imem_rdata;
            inst_pc_r <= req_addr_r;
            pc_r      <= req_addr_r + 32'd4;
          end else if (imem_ack && redirect) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
          end else if (redirect) begin
            pc_r <= target_s;
          end
        end
        DROP: begin
          if (imem_ack && redirect) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
          end else if (imem_ack) begin
            req_addr_r <= pc_r;
          end else if (redirect) begin
            pc_r <= target_s;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_r       <= target_s;
            req_addr_r <= target_s;
          end else if (inst_ready) begin
            req_addr_r <= pc_r;
          end
        end
        default: begin
          req_addr_r <= pc_r;
        end
      endcase
    end
  end

  assign imem_addr = req_addr_r;
  assign inst      = inst_r;
  assign inst_pc   = inst_pc_r;
  assign pc        = pc_r;

endmodule
